ps2_key_event_ctrl: RTL and testbench

//  Sequencer behind the PS/2 byte receiver. Consumes one scan-code byte per receiver done pulse and resolves
//  E0 (extended), F0 (break) and E1 (pause) prefixes into single key events.

---
 rtl/ps2_pkg.sv | 43 ++++
 rtl/ps2_evt_fifo.sv | 54 +++++
 rtl/ps2_key_event_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 key event sequencer: FSM states, prefix bytes,
// modifier key codes and event field widths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } ps2_state_t;

  localparam int CODE_W = 8;
  localparam int EVT_W  = CODE_W + 2;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_OVR    = 8'hFF;

  localparam logic [7:0] LSHIFT     = 8'h12;
  localparam logic [7:0] RSHIFT     = 8'h59;
  localparam logic [7:0] CTRL       = 8'h14;
  localparam logic [7:0] ALT        = 8'h11;
  localparam logic [7:0] CAPS       = 8'h58;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  // Bytes following E1 that belong to the pause sequence
  localparam logic [2:0] PAUSE_LEN  = 3'd7;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_OVR) || (b == PS2_RESEND);
  endfunction

  function automatic logic is_shift(input logic [7:0] b);
    return (b == LSHIFT) || (b == RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO; power-of-two depth, pointers wrap naturally and an
// occupancy counter one bit wider than the pointers distinguishes full from empty.
module ps2_evt_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_ok;
  logic              pop_ok;

  // A pop in the same cycle frees the slot being written when full
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0/E1 prefixes into {brk, ext, code} events,
// tracks modifiers and queues events. Define PS2_REPEAT_FILTER_EN to drop typematic repeats.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  PS2_Data,
  input  logic        PS2_Done_Sig,
  output logic [9:0]  EVT_Data,
  output logic        EVT_Valid,
  input  logic        EVT_Ready,
  output logic [3:0]  Mod_State,
  output logic        Ovf_Sig,
  output logic        Err_Sig
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  ps2_state_t         state;
  ps2_state_t         state_nxt;
  logic [2:0]         pcnt;
  logic [2:0]         pcnt_nxt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_hit;
  logic               emit;
  logic               emit_brk;
  logic               emit_ext;
  logic [CODE_W-1:0]  emit_code;
  logic               err_nxt;
  logic               repeat_hit;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               shift_q;
  logic               ctrl_q;
  logic               alt_q;
  logic               caps_q;
  logic               caps_held;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    emit_code = PS2_Data;
    err_nxt   = 1'b0;
    if (PS2_Done_Sig) begin
      case (state)
        IDLE: begin
          if (PS2_Data == PS2_EXT) begin
            state_nxt = EXT;
          end else if (PS2_Data == PS2_BRK) begin
            state_nxt = BRK;
          end else if (PS2_Data == PS2_PAUSE) begin
            state_nxt = PAUSE;
            pcnt_nxt  = PAUSE_LEN;
          end else if ((PS2_Data == PS2_ACK) || (PS2_Data == PS2_BAT)) begin
            state_nxt = IDLE;
          end else if (is_err_byte(PS2_Data)) begin
            err_nxt = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
        EXT: begin
          if (PS2_Data == PS2_BRK) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
            // E0 12 / E0 59 are the keyboard's fake-shift wrappers
            if (!is_shift(PS2_Data)) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
            end
          end
        end
        BRK: begin
          state_nxt = IDLE;
          emit      = 1'b1;
          emit_brk  = 1'b1;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          if (!is_shift(PS2_Data)) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = 1'b1;
          end
        end
        PAUSE: begin
          if (pcnt == 3'd1) begin
            state_nxt = IDLE;
            pcnt_nxt  = 3'd0;
            emit      = 1'b1;
            emit_ext  = 1'b1;
            emit_code = PAUSE_CODE;
          end else begin
            pcnt_nxt = pcnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = IDLE;
      pcnt_nxt  = 3'd0;
      err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      pcnt    <= 3'd0;
      tmo_cnt <= '0;
      Err_Sig <= 1'b0;
    end else begin
      state   <= state_nxt;
      pcnt    <= pcnt_nxt;
      Err_Sig <= err_nxt;
      if (PS2_Done_Sig || (state == IDLE) || tmo_hit) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [511:0] held_map;
  logic [8:0]   held_idx;

  assign held_idx   = {emit_ext, emit_code};
  assign repeat_hit = emit && !emit_brk && held_map[held_idx];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)     held_map           <= '0;
    else if (emit) held_map[held_idx] <= !emit_brk;
  end
`else
  assign repeat_hit = 1'b0;
`endif

  assign push = emit && !repeat_hit;
  assign pop  = EVT_Ready && !fifo_empty;

  ps2_evt_fifo #(
    .DATA_W (EVT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .push      (push),
    .push_data ({emit_brk, emit_ext, emit_code}),
    .pop       (pop),
    .head_data (EVT_Data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign EVT_Valid = !fifo_empty;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) Ovf_Sig <= 1'b0;
    else       Ovf_Sig <= push && fifo_full && !pop;
  end

  // Modifiers follow every emitted event, including ones the FIFO had to drop
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shift_q   <= 1'b0;
      ctrl_q    <= 1'b0;
      alt_q     <= 1'b0;
      caps_q    <= 1'b0;
      caps_held <= 1'b0;
    end else if (emit) begin
      if (!emit_ext && is_shift(emit_code)) shift_q <= !emit_brk;
      if (emit_code == CTRL)                ctrl_q  <= !emit_brk;
      if (emit_code == ALT)                 alt_q   <= !emit_brk;
      if (!emit_ext && (emit_code == CAPS)) begin
        if (emit_brk) begin
          caps_held <= 1'b0;
        end else begin
          if (!caps_held) caps_q <= !caps_q;
          caps_held <= 1'b1;
        end
      end
    end
  end

  assign Mod_State = {caps_q, alt_q, ctrl_q, shift_q};

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl: directed byte streams, expected events
// queued at issue time and checked by an independent monitor on the falling edge.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [7:0] PS2_Data = 8'h00;
  logic       PS2_Done_Sig = 1'b0;
  logic [9:0] EVT_Data;
  logic       EVT_Valid;
  logic       EVT_Ready = 1'b1;
  logic [3:0] Mod_State;
  logic       Ovf_Sig;
  logic       Err_Sig;

  int n_vec = 0;
  int n_err = 0;
  int err_seen = 0;
  int ovf_seen = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .PS2_Data     (PS2_Data),
    .PS2_Done_Sig (PS2_Done_Sig),
    .EVT_Data     (EVT_Data),
    .EVT_Valid    (EVT_Valid),
    .EVT_Ready    (EVT_Ready),
    .Mod_State    (Mod_State),
    .Ovf_Sig      (Ovf_Sig),
    .Err_Sig      (Err_Sig)
  );

  always #5 CLK = ~CLK;

  // Monitor: every handshake pops the scoreboard
  always @(negedge CLK) begin
    if (RSTn) begin
      if (Err_Sig) err_seen++;
      if (Ovf_Sig) ovf_seen++;
      if (EVT_Valid && EVT_Ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL evt_unexpected: got %03h, required no event", EVT_Data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (EVT_Data !== e) begin
            n_err++;
            $display("FAIL evt_data: got %03h, required %03h", EVT_Data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    PS2_Data     = b;
    PS2_Done_Sig = 1'b1;
    @(posedge CLK); #1;
    PS2_Done_Sig = 1'b0;
  endtask

  task automatic expect_evt(input logic [9:0] e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    chk("reset_outputs", {EVT_Valid, EVT_Data, Mod_State, Ovf_Sig, Err_Sig}, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || EVT_Valid); i++) @(negedge CLK);
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) @(posedge CLK);
    do_reset();

    // Latency and stability under back-pressure
    EVT_Ready = 1'b0;
    expect_evt(10'h01C);
    send_byte(8'h1C);
    chk("latency_valid", EVT_Valid, 1);
    chk("latency_data", EVT_Data, 10'h01C);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("hold_stable", {EVT_Valid, EVT_Data}, {1'b1, 10'h01C});
    end
    EVT_Ready = 1'b1;
    drain();

    // Extended break and fake-shift suppression
    do_reset();
    expect_evt(10'h375);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    expect_evt(10'h17C);
    send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);
    drain();

    // Shift tracking
    expect_evt(10'h012);
    send_byte(8'h12);
    chk("shift_set", Mod_State, 4'b0001);
    expect_evt(10'h01C);
    send_byte(8'h1C);
    expect_evt(10'h212);
    send_byte(8'hF0); send_byte(8'h12);
    chk("shift_clr", Mod_State, 4'b0000);
    drain();

    // Caps lock toggles on each fresh make
    expect_evt(10'h058);
    send_byte(8'h58);
    chk("caps_on", Mod_State, 4'b1000);
    expect_evt(10'h258);
    send_byte(8'hF0); send_byte(8'h58);
    chk("caps_hold", Mod_State, 4'b1000);
    expect_evt(10'h058);
    send_byte(8'h58);
    chk("caps_off", Mod_State, 4'b0000);
    expect_evt(10'h258);
    send_byte(8'hF0); send_byte(8'h58);
    drain();

    // Typematic repeat
    do_reset();
    expect_evt(10'h01C);
`ifndef PS2_REPEAT_FILTER_EN
    expect_evt(10'h01C);
    expect_evt(10'h01C);
`endif
    expect_evt(10'h21C);
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    drain();

    // Pause sequence collapses to one event
    expect_evt(10'h177);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    drain();
    chk("pause_mods", Mod_State, 4'b0000);

    // Prefix timeout
    e0 = err_seen;
    send_byte(8'hE0);
    repeat (TMO + 6) @(posedge CLK);
    chk("tmo_err", err_seen - e0, 1);
    expect_evt(10'h01C);
    send_byte(8'h1C);
    drain();

    // Error byte in IDLE
    e0 = err_seen;
    send_byte(8'h00);
    repeat (3) @(posedge CLK);
    chk("err_byte", err_seen - e0, 1);
    chk("err_no_evt", EVT_Valid, 0);

    // Overflow, then simultaneous push and pop on a full FIFO
    do_reset();
    EVT_Ready = 1'b0;
    e0 = ovf_seen;
    expect_evt(10'h01C); expect_evt(10'h01B); expect_evt(10'h023); expect_evt(10'h02B);
    send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23); send_byte(8'h2B);
    send_byte(8'h34);
    repeat (2) @(posedge CLK);
    chk("ovf_pulse", ovf_seen - e0, 1);
    chk("ovf_full_head", {EVT_Valid, EVT_Data}, {1'b1, 10'h01C});
    expect_evt(10'h033);
    @(posedge CLK); #1;
    EVT_Ready    = 1'b1;
    PS2_Data     = 8'h33;
    PS2_Done_Sig = 1'b1;
    @(posedge CLK); #1;
    PS2_Done_Sig = 1'b0;
    repeat (2) @(posedge CLK);
    chk("ovf_pushpop", ovf_seen - e0, 1);
    drain();

    // Reset in the middle of an extended sequence
    EVT_Ready = 1'b0;
    send_byte(8'h12);
    chk("pre_reset_shift", Mod_State, 4'b0001);
    send_byte(8'hE0);
    do_reset();
    EVT_Ready = 1'b1;
    expect_evt(10'h01C);
    send_byte(8'h1C);
    drain();

    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
